apb_slave_regfile: RTL and testbench

Parametrised APB slave: the next generation of the fixed single-register slave. It provides a DEPTH-word register file with byte strobes and configurable wait states. It flags errors on misaligned or out-of-range addresses, and aborts cleanly when PSEL drops. It sits on the APB bus opposite the master block, shares PCLK, and drives PREADY and PSLVERR back to the master.

---
 rtl/apb_slave_regfile_pkg.sv | 20 ++
 rtl/apb_slave_regfile_if.sv | 30 +++
 rtl/apb_slave_regfile_mem.sv | 31 +++
 rtl/apb_slave_regfile.sv | 107 ++++++++++
 tb/tb_apb_slave_regfile.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/apb_slave_regfile_pkg.sv
// Shared types and helpers for the APB register-file slave.
// Lane count and index shift are derived from the data width.
package apb_pkg;

  localparam int MAX_WAIT = 15;

  typedef enum logic {
    IDLE,
    ACCESS
  } state_t;

  function automatic int strb_w(input int dw);
    return dw / 8;
  endfunction

  function automatic int idx_shift(input int dw);
    return $clog2(dw / 8);
  endfunction

endpackage

// File: rtl/apb_slave_regfile_if.sv
// APB bus bundle between master and register-file slave.
// Bus signals only; the clock and reset stay plain ports.
interface apb_slave_regfile_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [ADDR_W-1:0]     PRWADDR;
  logic [DATA_W-1:0]     PRWDATA;
  logic [DATA_W/8-1:0]   PSTRB;
  logic [DATA_W-1:0]     PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE,
    output PRWADDR, PRWDATA, PSTRB,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE,
    input  PRWADDR, PRWDATA, PSTRB,
    output PRDATA, PREADY, PSLVERR
  );

endinterface

// File: rtl/apb_slave_regfile_mem.sv
// DEPTH x DATA_W storage: byte-strobe write, async read.
// Out-of-range read indices return zero.
module apb_regfile_mem #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int IW     = 5
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                we,
  input  logic [IW-1:0]       widx,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] strb,
  input  logic [IW-1:0]       ridx,
  output logic [DATA_W-1:0]   rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      for (int b = 0; b < DATA_W/8; b++)
        if (strb[b]) mem[widx][b*8 +: 8] <= wdata[b*8 +: 8];
    end
  end

  assign rdata = (ridx < IW'(DEPTH)) ? mem[ridx] : '0;

endmodule

// File: rtl/apb_slave_regfile.sv
// APB slave with DEPTH-word register file, byte strobes,
// configurable wait states, error decode and clean abort.
module apb_slave_regfile
  import apb_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int DEPTH       = 16,
  parameter int WAIT_CYCLES = 0
) (
  input logic               PCLK,
  input logic               PRESET,
  apb_slave_regfile_if.slave bus
);

  localparam int SW = strb_w(DATA_W);
  localparam int SH = idx_shift(DATA_W);
  localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam int IW = $clog2(DEPTH + 1);
  localparam logic [ADDR_W-1:0] AMASK = ADDR_W'((64'd1 << SH) - 64'd1);

  state_t            state, nxt;
  logic              capture;
  logic              wr_q;
  logic              err_q;
  logic [IW-1:0]     idx_q;
  logic [DATA_W-1:0] data_q;
  logic [SW-1:0]     strb_q;
  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] prdata_q;

  logic [ADDR_W-1:0] idx_full;
  logic              err;
  logic [DATA_W-1:0] rdata;
  logic              ready;
  logic              we;

  assign idx_full = bus.PRWADDR >> SH;
  assign err = ((bus.PRWADDR & AMASK) != '0)
            || (idx_full >= ADDR_W'(DEPTH));

  always_comb begin
    nxt     = state;
    capture = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.PSEL && !bus.PENABLE) begin
          capture = 1'b1;
          nxt     = ACCESS;
        end
      end
      ACCESS: begin
        if (!bus.PSEL || cnt == '0) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (!PRESET) begin
      state    <= IDLE;
      wr_q     <= 1'b0;
      err_q    <= 1'b0;
      idx_q    <= '0;
      data_q   <= '0;
      strb_q   <= '0;
      cnt      <= '0;
      prdata_q <= '0;
    end else begin
      state <= nxt;
      if (capture) begin
        wr_q     <= bus.PWRITE;
        err_q    <= err;
        idx_q    <= idx_full[IW-1:0];
        data_q   <= bus.PRWDATA;
        strb_q   <= bus.PSTRB;
        cnt      <= CW'(WAIT_CYCLES);
        prdata_q <= err ? '0 : rdata;
      end else if (state == ACCESS && cnt != '0 && bus.PSEL) begin
        cnt <= cnt - CW'(1);
      end
    end
  end

  assign ready = (state == ACCESS) && (cnt == '0) && bus.PSEL;
  assign we    = ready && wr_q && !err_q;

  assign bus.PREADY  = ready;
  assign bus.PSLVERR = ready && err_q;
  assign bus.PRDATA  = prdata_q;

  apb_regfile_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IW     (IW)
  ) u_mem (
    .clk   (PCLK),
    .clr   (!PRESET),
    .we    (we),
    .widx  (idx_q),
    .wdata (data_q),
    .strb  (strb_q),
    .ridx  (idx_full[IW-1:0]),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Bench for apb_slave_regfile: two instances (0 and 3 wait
// states) checked against a word-array reference model.
module tb_apb_slave_regfile;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        tgt = 1'b0;
  logic        psel = 1'b0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  strb = '0;

  apb_slave_regfile_if #(.ADDR_W(32), .DATA_W(32)) b0 ();
  apb_slave_regfile_if #(.ADDR_W(32), .DATA_W(32)) b3 ();

  assign b0.PSEL    = psel && !tgt;
  assign b3.PSEL    = psel && tgt;
  assign b0.PENABLE = penable;
  assign b3.PENABLE = penable;
  assign b0.PWRITE  = pwrite;
  assign b3.PWRITE  = pwrite;
  assign b0.PRWADDR = addr;
  assign b3.PRWADDR = addr;
  assign b0.PRWDATA = wdata;
  assign b3.PRWDATA = wdata;
  assign b0.PSTRB   = strb;
  assign b3.PSTRB   = strb;

  logic        rdy, serr;
  logic [31:0] rd;
  assign rdy  = tgt ? b3.PREADY  : b0.PREADY;
  assign serr = tgt ? b3.PSLVERR : b0.PSLVERR;
  assign rd   = tgt ? b3.PRDATA  : b0.PRDATA;

  apb_slave_regfile #(
    .DATA_W(32), .ADDR_W(32), .DEPTH(16), .WAIT_CYCLES(0)
  ) d0 (
    .PCLK(clk), .PRESET(rst_n), .bus(b0.slave)
  );

  apb_slave_regfile #(
    .DATA_W(32), .ADDR_W(32), .DEPTH(16), .WAIT_CYCLES(3)
  ) d3 (
    .PCLK(clk), .PRESET(rst_n), .bus(b3.slave)
  );

  logic [31:0] m [2][16];
  int checks = 0;
  int passes = 0;
  int fails = 0;
  logic [31:0] last_rd;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int t = 0; t < 2; t++)
      for (int i = 0; i < 16; i++) m[t][i] = '0;
  endtask

  // Full setup+access transfer; leaves the bus selected so the
  // next call starts its setup phase on the very next cycle.
  task automatic xfer(input bit t, input bit w, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] s);
    int n;
    int idx;
    bit e;
    logic [31:0] exp_rd;
    idx = int'(a >> 2);
    e = (a[1:0] != 2'b00) || (idx >= 16);
    exp_rd = e ? 32'h0 : m[t][idx];
    @(negedge clk);
    tgt = t; psel = 1'b1; penable = 1'b0;
    pwrite = w; addr = a; wdata = d; strb = s;
    @(negedge clk);
    penable = 1'b1;
    #1;
    n = 1;
    while (rdy !== 1'b1 && n < 40) begin
      @(negedge clk); #1;
      n++;
    end
    check("ready_cycle", 64'(n), t ? 64'd4 : 64'd1);
    check("pslverr", 64'(serr), 64'(e));
    check("prdata", 64'(rd), 64'(exp_rd));
    last_rd = rd;
    if (w && !e)
      for (int b = 0; b < 4; b++)
        if (s[b]) m[t][idx][b*8 +: 8] = d[b*8 +: 8];
  endtask

  task automatic idle();
    @(negedge clk);
    psel = 1'b0; penable = 1'b0;
  endtask

  initial begin
    model_clear();
    // Reset held with PSEL asserted
    psel = 1'b1; rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_pready0", 64'(b0.PREADY), 64'd0);
    check("rst_pready3", 64'(b3.PREADY), 64'd0);
    check("rst_pslverr", 64'(b0.PSLVERR), 64'd0);
    check("rst_prdata", 64'(b0.PRDATA), 64'd0);
    rst_n = 1'b1; psel = 1'b0;
    xfer(0, 0, 32'h8, 32'h0, 4'h0);
    check("rst_read8", 64'(last_rd), 64'd0);

    xfer(0, 1, 32'h4, 32'hDEADBEEF, 4'hF);
    xfer(0, 0, 32'h4, 32'h0, 4'h0);
    check("wr_rd", 64'(last_rd), 64'hDEADBEEF);
    xfer(0, 1, 32'h4, 32'h11223344, 4'b0101);
    xfer(0, 0, 32'h4, 32'h0, 4'hF);
    check("strb_merge", 64'(last_rd), 64'hDE22BE44);

    xfer(1, 1, 32'h0, 32'hCAFEF00D, 4'hF);
    xfer(1, 0, 32'h0, 32'h0, 4'h0);
    check("wait_b2b", 64'(last_rd), 64'hCAFEF00D);

    xfer(0, 1, 32'h2, 32'h55555555, 4'hF);
    xfer(0, 0, 32'h0, 32'h0, 4'h0);
    xfer(0, 0, 32'h40, 32'h0, 4'h0);
    check("oor_prdata", 64'(last_rd), 64'd0);
    idle();

    // PENABLE without setup in IDLE is ignored
    @(negedge clk);
    tgt = 1'b0; psel = 1'b1; penable = 1'b1; pwrite = 1'b1;
    addr = 32'h8; wdata = 32'hFFFFFFFF; strb = 4'hF;
    @(negedge clk); #1;
    check("proto_pready", 64'(rdy), 64'd0);
    psel = 1'b0; penable = 1'b0;
    xfer(0, 0, 32'h8, 32'h0, 4'h0);

    // Abort: drop PSEL in the 2nd wait cycle of a write
    xfer(1, 0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    tgt = 1'b1; psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
    addr = 32'h0; wdata = 32'h12345678; strb = 4'hF;
    @(negedge clk); penable = 1'b1;
    @(negedge clk); psel = 1'b0; #1;
    check("abort_pready", 64'(rdy), 64'd0);
    check("abort_pslverr", 64'(serr), 64'd0);
    @(negedge clk); penable = 1'b0; #1;
    check("abort_prdata", 64'(rd), 64'(m[1][0]));
    xfer(1, 0, 32'h0, 32'h0, 4'h0);
    check("abort_nowrite", 64'(last_rd), 64'hCAFEF00D);

    // Reset during ACCESS discards the write and clears all
    @(negedge clk);
    tgt = 1'b1; psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
    addr = 32'h4; wdata = 32'h0BADF00D; strb = 4'hF;
    @(negedge clk); penable = 1'b1; rst_n = 1'b0;
    @(negedge clk); #1;
    check("midrst_pready", 64'(rdy), 64'd0);
    check("midrst_pslverr", 64'(serr), 64'd0);
    check("midrst_prdata", 64'(rd), 64'd0);
    rst_n = 1'b1; psel = 1'b0; penable = 1'b0;
    model_clear();
    xfer(1, 0, 32'h4, 32'h0, 4'h0);
    xfer(0, 0, 32'h4, 32'h0, 4'h0);
    check("midrst_cleared", 64'(last_rd), 64'd0);

    // Randomised traffic on both instances
    for (int k = 0; k < 80; k++) begin
      xfer(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           32'($urandom_range(0, 32'h47)), $urandom(),
           4'($urandom_range(0, 15)));
      if ($urandom_range(0, 3) == 0) idle();
    end
    idle();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
